// File: rtl/led_pwm_driver.sv
// led_pwm_driver: per-LED PWM brightness with staged duties committed
// atomically at the PWM period boundary; registered, glitch-free outputs.
module led_pwm_driver #(
   parameter int NUM_LEDS = 8,
   parameter int DUTY_W = 8,
   parameter int PRESCALE = 64,
   parameter bit ACTIVE_LOW = 1'b0,
   localparam int CW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1,
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [CW-1:0]       wr_chan,
   input  logic [DUTY_W-1:0]   wr_duty,
   input  logic                commit,
   output logic                period_start,
   output logic [NUM_LEDS-1:0] leds
);
   logic [PW-1:0] prescaler;
   logic [DUTY_W-1:0] pwm_cnt;
   logic [DUTY_W-1:0] stage [NUM_LEDS];
   logic [DUTY_W-1:0] active [NUM_LEDS];
   logic pending, tick, boundary, wr_fire;
   assign tick = prescaler == PW'(PRESCALE - 1);
   assign boundary = tick && &pwm_cnt;
   assign wr_ready = !pending;
   assign wr_fire = wr_valid && wr_ready && 32'(wr_chan) < NUM_LEDS;
   // stalling writes while pending keeps a committed set from being torn
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         pwm_cnt <= '0;
         pending <= 1'b0;
         period_start <= 1'b0;
         leds <= {NUM_LEDS{ACTIVE_LOW}};
         for (int i = 0; i < NUM_LEDS; i++) begin
            stage[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) pwm_cnt <= pwm_cnt + 1'b1;
         period_start <= boundary;
         pending <= (boundary && pending) ? 1'b0 : (pending || commit);
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (boundary && pending) active[i] <= stage[i];
            if (wr_fire && wr_chan == CW'(i)) stage[i] <= wr_duty;
            leds[i] <= (pwm_cnt < active[i]) ^ ACTIVE_LOW;
         end
      end
   end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: two DUT configurations driven by shared stimulus,
// checked every cycle against a time-arithmetic reference model.
module tb_led_pwm_driver;
   localparam int P [2] = '{2, 1};
   localparam int NL [2] = '{8, 6};
   localparam bit AL [2] = '{1'b0, 1'b1};
   logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, commit = 1'b0;
   logic [2:0] wr_chan = '0;
   logic [3:0] wr_duty = '0;
   logic rdy0, rdy1, ps0, ps1;
   logic [7:0] leds0;
   logic [5:0] leds1;
   int errs = 0, checks = 0;
   int t [2];
   int stage [2][8];
   int active [2][8];
   bit pend [2];
   logic [7:0] e_leds [2];
   bit e_ps [2];

   led_pwm_driver #(.NUM_LEDS(8), .DUTY_W(4), .PRESCALE(2), .ACTIVE_LOW(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy0), .wr_chan(wr_chan),
      .wr_duty(wr_duty), .commit(commit), .period_start(ps0), .leds(leds0));
   led_pwm_driver #(.NUM_LEDS(6), .DUTY_W(4), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy1), .wr_chan(wr_chan),
      .wr_duty(wr_duty), .commit(commit), .period_start(ps1), .leds(leds1));

   always #5 clk = ~clk;

   // model: position in the period follows from cycles elapsed since reset
   always @(posedge clk or negedge rst_n) begin : model
      int per, pos;
      bit b, p;
      logic [7:0] lv;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            t[k] = 0;
            pend[k] = 1'b0;
            e_ps[k] = 1'b0;
            lv = '0;
            for (int i = 0; i < 8; i++) begin
               stage[k][i] = 0;
               active[k][i] = 0;
               if (i < NL[k]) lv[i] = AL[k];
            end
            e_leds[k] = lv;
         end else begin
            per = P[k] * 16;
            pos = t[k] % per;
            b = pos == per - 1;
            p = pend[k];
            lv = '0;
            for (int i = 0; i < NL[k]; i++) lv[i] = ((pos / P[k]) < active[k][i]) ^ AL[k];
            e_leds[k] = lv;
            e_ps[k] = b;
            if (b && p) begin
               for (int i = 0; i < 8; i++) active[k][i] = stage[k][i];
               pend[k] = 1'b0;
            end else if (commit && !p) pend[k] = 1'b1;
            if (wr_valid && !p && int'(wr_chan) < NL[k]) stage[k][wr_chan] = int'(wr_duty);
            t[k]++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      chk("leds0", 32'(leds0), 32'(e_leds[0]));
      chk("leds1", 32'(leds1), 32'(e_leds[1][5:0]));
      chk("period_start0", 32'(ps0), 32'(e_ps[0]));
      chk("period_start1", 32'(ps1), 32'(e_ps[1]));
      chk("wr_ready0", 32'(rdy0), 32'(!pend[0]));
      chk("wr_ready1", 32'(rdy1), 32'(!pend[1]));
   endtask

   task automatic wr(input int ch, input int d);
      wr_valid = 1'b1;
      wr_chan = 3'(ch);
      wr_duty = 4'(d);
      cyc();
      wr_valid = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) cyc();
      chk("reset_leds0", 32'(leds0), 32'h00);
      chk("reset_leds1", 32'(leds1), 32'h3F);
      rst_n = 1'b1;
      wr(0, 4); wr(1, 0); wr(2, 15); wr(3, 2);
      do_commit();
      repeat (70) cyc();
      do_commit();
      wr_valid = 1'b1; wr_chan = 3'd3; wr_duty = 4'd9;
      repeat (40) cyc();
      wr_valid = 1'b0;
      do_commit();
      repeat (70) cyc();
      wr_valid = 1'b1; wr_chan = 3'd5; wr_duty = 4'd6; commit = 1'b1;
      cyc();
      wr_valid = 1'b0; commit = 1'b0;
      repeat (70) cyc();
      for (n = 0; n < 100 && !(!pend[0] && t[0] % 32 == 31); n++) cyc();
      chk("boundary_wait", 32'(n < 100), 32'd1);
      do_commit();
      repeat (70) cyc();
      wr(7, 11); wr(6, 13);
      do_commit(); do_commit(); do_commit();
      repeat (70) cyc();
      wr(4, 7);
      do_commit();
      cyc();
      rst_n = 1'b0;
      #1;
      chk("async_leds0", 32'(leds0), 32'h00);
      chk("async_leds1", 32'(leds1), 32'h3F);
      chk("async_ready0", 32'(rdy0), 32'd1);
      chk("async_ps0", 32'(ps0), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (80) cyc();
      repeat (3000) begin
         wr_valid = $urandom_range(0, 9) < 3;
         wr_chan = 3'($urandom);
         wr_duty = 4'($urandom);
         commit = $urandom_range(0, 29) == 0;
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
